// File: rtl/spm_host.sv
// rtl/spm_host.sv - host FSM that streams Y into a serial-parallel multiplier core and deserialises the product.
// Optional SPM_HOST_SIGNED_Y_EN: sign-extend y_in (two's complement multiplier); default treats y_in as unsigned.
module spm_host #(
    parameter int SIZE = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIZE-1:0]     x_in,
    input  logic [SIZE-1:0]     y_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*SIZE-1:0]   prod,
    output logic                busy,
    output logic                spm_rst,
    output logic [SIZE-1:0]     spm_x,
    output logic                spm_y,
    input  logic                spm_p
);

    localparam int KW = $clog2(2*SIZE+1);
    localparam logic [KW-1:0] K_EXT  = KW'(SIZE);
    localparam logic [KW-1:0] K_LAST = KW'(2*SIZE);

    typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

    state_t          state;
    logic [KW-1:0]   k;
    logic [SIZE-1:0] x_lat;
    logic [SIZE-1:0] y_lat;
    logic [SIZE-1:0] y_sh;
    logic            ext_bit;

`ifdef SPM_HOST_SIGNED_Y_EN
    assign ext_bit = y_lat[SIZE-1];
`else
    assign ext_bit = 1'b0;
`endif

    assign y_sh     = y_lat >> k;
    assign spm_x    = x_lat;
    assign busy     = (state != IDLE);
    assign in_ready = (state == IDLE) && !rst;
    // Core reset must follow rst combinationally so an abort clears it immediately.
    assign spm_rst  = rst || (state == CLR);

    always_comb begin
        spm_y = 1'b0;
        if (state == RUN) begin
            if (k < K_EXT)
                spm_y = y_sh[0];
            else if (k < K_LAST)
                spm_y = ext_bit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            x_lat     <= '0;
            y_lat     <= '0;
            prod      <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_lat <= x_in;
                        y_lat <= y_in;
                        state <= CLR;
                    end
                end
                CLR: begin
                    k     <= '0;
                    state <= RUN;
                end
                RUN: begin
                    // The core's output is one cycle late, so the k=0 cycle carries no product bit.
                    if (k != '0)
                        prod <= {spm_p, prod[2*SIZE-1:1]};
                    if (k == K_LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spm_host.sv
// tb/tb_spm_host.sv - self-checking bench for spm_host with SIZE=8 and a behavioural serial-parallel multiplier core.
module tb_spm_host;

    localparam int SIZE = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  x_in = '0;
    logic [7:0]  y_in = '0;
    logic        in_ready, out_valid, busy, spm_rst, spm_y, spm_p;
    logic [15:0] prod;
    logic [7:0]  spm_x;

    always #5 clk = ~clk;

    spm_host #(.SIZE(SIZE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
        .prod(prod), .busy(busy), .spm_rst(spm_rst), .spm_x(spm_x),
        .spm_y(spm_y), .spm_p(spm_p)
    );

    // Serial-parallel multiplier core: signed x, one y bit per cycle, registered product bit.
    logic signed [17:0] core_acc, core_sum, core_xs;
    always_comb begin
        core_xs  = {{10{spm_x[7]}}, spm_x};
        core_sum = core_acc + (spm_y ? core_xs : 18'sd0);
    end
    always @(posedge clk or posedge spm_rst) begin
        if (spm_rst) begin
            core_acc <= '0;
            spm_p    <= 1'b0;
        end else begin
            spm_p    <= core_sum[0];
            core_acc <= core_sum >>> 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] ref_prod(input logic [7:0] x, input logic [7:0] y);
        logic signed [31:0] xs, ys, p;
        xs = {{24{x[7]}}, x};
`ifdef SPM_HOST_SIGNED_Y_EN
        ys = {{24{y[7]}}, y};
`else
        ys = {24'b0, y};
`endif
        p = xs * ys;
        return p[15:0];
    endfunction

    function automatic logic ext_of(input logic [7:0] y);
`ifdef SPM_HOST_SIGNED_Y_EN
        return y[7];
`else
        return 1'b0;
`endif
    endfunction

    // Transaction model: phase 0 waiting, 1 computing, 2 result held; m_cnt counts edges since acceptance.
    int          cyc = 0;
    int          m_phase, m_cnt;
    logic [7:0]  m_x, m_y;
    logic [15:0] m_exp, m_last;
    int          acc_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_x     <= '0;
            m_y     <= '0;
            m_exp   <= '0;
            m_last  <= '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_x     <= x_in;
                    m_y     <= y_in;
                    m_exp   <= ref_prod(x_in, y_in);
                    m_cnt   <= 0;
                    m_phase <= 1;
                    acc_cyc.push_back(cyc);
                end
                1: if (m_cnt == 2*SIZE+1) begin
                    m_phase <= 2;
                    m_last  <= m_exp;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    function automatic logic exp_spm_y();
        int kk;
        if (m_phase != 1 || m_cnt < 1) return 1'b0;
        kk = m_cnt - 1;
        if (kk < SIZE) return m_y[kk];
        if (kk < 2*SIZE) return ext_of(m_y);
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_spm_rst", spm_rst, 1);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_prod", prod, 0);
        end else begin
            chk("in_ready", in_ready, m_phase == 0);
            chk("busy", busy, m_phase != 0);
            chk("out_valid", out_valid, m_phase == 2);
            chk("spm_x", spm_x, m_x);
            chk("spm_rst", spm_rst, (m_phase == 1) && (m_cnt == 0));
            chk("spm_y", spm_y, exp_spm_y());
            if (m_phase == 2) chk("prod_done", prod, m_exp);
            if (m_phase == 0) chk("prod_idle", prod, m_last);
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) chk("ready_timeout", 1, 0);
    endtask

    task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic [15:0] lit, input int hold);
        int n;
        in_valid = 1'b1; x_in = x; y_in = y; out_ready = 1'b0;
        wait_ready();
        @(posedge clk); #1;
        in_valid = 1'b0; x_in = ~x; y_in = ~y;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", n, 18);
        chk("prod_lit", prod, lit);
        for (int i = 0; i < hold; i++) begin
            in_valid = (i == 2);
            @(posedge clk); #1;
            chk("bp_prod", prod, lit);
            chk("bp_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("handoff_valid", out_valid, 0);
        chk("handoff_ready", in_ready, 1);
        chk("handoff_prod", prod, lit);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int n, rises, got, base;
        logic last_ov;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 0);
        chk("reset_prod", prod, 0);
        chk("reset_spm_rst", spm_rst, 1);
        rst = 1'b0;
        #1;
        chk("release_in_ready", in_ready, 1);
        @(posedge clk); #1;

`ifdef SPM_HOST_SIGNED_Y_EN
        do_op(8'd50, 8'hCE, 16'hF63C, 0);
        do_op(8'hFF, 8'h01, 16'hFFFF, 0);
        do_op(8'h80, 8'hFF, 16'h0080, 0);
`else
        do_op(8'd50, 8'hCE, 16'h283C, 0);
        do_op(8'hFF, 8'h01, 16'hFFFF, 0);
        do_op(8'h80, 8'hFF, 16'h8080, 0);
`endif
        do_op(8'h12, 8'h34, 16'h03A8, 5);

        // Abort mid-RUN at k=5.
        in_valid = 1'b1; x_in = 8'd9; y_in = 8'd7;
        wait_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_spm_rst", spm_rst, 1);
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("abort_spm_rst_hold", spm_rst, 1);
        rst = 1'b0;
        #1;
        chk("abort_release_ready", in_ready, 1);
        rises = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_valid) rises++;
        end
        chk("abort_no_result", rises, 0);
        do_op(8'd3, 8'd4, 16'h000C, 0);

        // Back-to-back with in_valid and out_ready held high.
        base = acc_cyc.size();
        in_valid = 1'b1; x_in = 8'hFF; y_in = 8'hFF; out_ready = 1'b1;
        got = 0; n = 0; last_ov = 1'b0;
        while (got < 3 && n < 200) begin
            @(posedge clk); #1; n++;
            if (out_valid) begin
                got++;
`ifdef SPM_HOST_SIGNED_Y_EN
                chk("b2b_prod", prod, 16'h0001);
`else
                chk("b2b_prod", prod, 16'hFF01);
`endif
            end
        end
        in_valid = 1'b0;
        chk("b2b_count", got, 3);
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("b2b_idle", busy, 0);
        out_ready = 1'b0;
        chk("b2b_accepts", acc_cyc.size() - base, 3);
        for (int i = base + 1; i < acc_cyc.size(); i++)
            chk("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 20);
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spm_host.md
SPM_HOST -- requirements
Module: spm_host

Interface
REQ-001 Parameter SIZE, default 32, operand width in bits; product width is 2*SIZE.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 x_in  input  SIZE  multiplicand, two's complement.
REQ-007 y_in  input  SIZE  multiplier, streamed LSB-first to the core.
REQ-008 out_valid  output  1  prod holds a completed result.
REQ-009 out_ready  input  1  consumer accepts prod.
REQ-010 prod  output  2*SIZE  product x_in*y_in modulo 2^(2*SIZE).
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 spm_rst  output  1  clear to the serial-parallel multiplier core; drives the core's asynchronous reset.
REQ-013 spm_x  output  SIZE  parallel multiplicand to the core.
REQ-014 spm_y  output  1  serial multiplier bit to the core.
REQ-015 spm_p  input  1  serial product bit from the core; it is registered in the core, so bit k appears one cycle after spm_y carries bit k.

Function
REQ-016 The FSM SHALL have exactly four states, IDLE, CLR, RUN and DONE, encoded in 2 bits.
REQ-017 IDLE: in_ready=1; on in_valid&&in_ready, the block SHALL latch x_in and y_in and go to CLR.
REQ-018 in_ready SHALL be 0 in CLR, RUN and DONE; in_valid in those states SHALL be ignored and SHALL NOT disturb the latched operands.
REQ-019 CLR lasts 1 cycle: spm_rst=1, then the block SHALL go to RUN with counter k=0.
REQ-020 RUN lasts 2*SIZE+1 cycles, k=0..2*SIZE; counter width is clog2(2*SIZE+1).
REQ-021 spm_y in RUN SHALL be Y[k] for k<SIZE, the extension bit (REQ-031/032) for SIZE<=k<2*SIZE, and 0 for k=2*SIZE.
REQ-022 spm_y SHALL be 0 outside RUN.
REQ-023 spm_x SHALL equal the latched x in every state.
REQ-024 On the clock edge ending each RUN cycle k>=1, the block SHALL shift spm_p into the MSB of the product shift register (right shift).
REQ-025 After 2*SIZE captures, the LSB of the register SHALL hold product bit 0.
REQ-026 On the edge ending k=2*SIZE, the block SHALL go to DONE.
REQ-027 out_valid SHALL rise exactly 2*SIZE+2 edges after the accepting edge.
REQ-028 DONE: out_valid=1, and prod SHALL stay stable until out_valid&&out_ready; the block then SHALL return to IDLE and drop out_valid on the next edge.
REQ-029 prod SHALL keep its last value while in IDLE; it changes only during RUN shifting.
REQ-030 A new operand pair SHALL NOT be accepted in the same cycle as the result handoff; acceptance requires IDLE.

Configuration
REQ-031 With macro SPM_HOST_SIGNED_Y_EN defined, the extension bit SHALL be Y[SIZE-1] (sign extension), so y_in is treated as two's complement.
REQ-032 Without SPM_HOST_SIGNED_Y_EN, the extension bit SHALL be 0, so y_in is treated as unsigned.

Reset
REQ-033 While rst=1: state=IDLE, k=0, latched operands=0, prod=0, out_valid=0, busy=0, in_ready=0.
REQ-034 spm_rst SHALL equal rst OR (state==CLR), with no register between rst and spm_rst.
REQ-035 Assertion of rst in any state, including mid-RUN, SHALL abort the operation with no result emitted; in_ready SHALL be 1 in the first cycle after release.

Verification
REQ-036 The bench SHALL run with SIZE=8 and the team's serial-parallel multiplier core attached to the spm_* ports.
REQ-037 Unsigned build: x=50, y=0xCE -> prod=0x283C, with out_valid rising 18 edges after acceptance.
REQ-038 SIGNED build: x=50, y=0xCE (-50) -> prod=0xF63C; x=0x80, y=0xFF -> prod=0x0080.
REQ-039 Unsigned build: x=0xFF, y=0x01 -> prod=0xFFFF; x=0x80, y=0xFF -> prod=0x8080.
REQ-040 Backpressure: out_ready held 0 for 5 cycles in DONE -> prod and out_valid stay stable; in_valid pulsed meanwhile is ignored; a 1-cycle out_ready returns the block to IDLE.
REQ-041 rst asserted at RUN k=5 -> out_valid never rises and spm_rst=1 during rst; a following x=3, y=4 -> prod=0x000C.
REQ-042 Back-to-back: in_valid held high with x=0xFF, y=0xFF, out_ready=1 -> prod=0xFF01 unsigned or 0x0001 signed each time; successive acceptances 2*SIZE+4 = 20 cycles apart.
